// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with fixed 5/10-cycle busy latency.
// Optional MDU_EARLY_BUSY_EN: busy also asserts combinationally in the launch cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] md_out
);
    logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
    logic [3:0]  r_cnt;
    logic [31:0] w_hi_nxt, w_lo_nxt, w_res_hi_nxt, w_res_lo_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_idle, w_launch, w_is_mul, w_signed, w_neg_a, w_neg_b;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_quo, w_rem;

    assign w_idle   = (r_cnt == 4'd0);
    assign w_launch = w_idle & start & ~req & (md_op >= 4'd1) & (md_op <= 4'd4);
    assign w_is_mul = (md_op == 4'd1) || (md_op == 4'd2);
    assign w_signed = (md_op == 4'd1) || (md_op == 4'd3);

    // Sign-extending to 64 bits makes one unsigned multiplier serve both mult and multu.
    assign w_ext_a = {{32{w_signed & rs_val[31]}}, rs_val};
    assign w_ext_b = {{32{w_signed & rt_val[31]}}, rt_val};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division via magnitudes; this also gives 0x80000000 / -1 = 0x80000000 rem 0.
    assign w_neg_a = w_signed & rs_val[31];
    assign w_neg_b = w_signed & rt_val[31];
    assign w_abs_a = w_neg_a ? -rs_val : rs_val;
    assign w_abs_b = w_neg_b ? -rt_val : rt_val;
    assign w_q     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
    assign w_r     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    assign w_rem   = w_neg_a ? -w_r : w_r;

    // State register: reset wins over launch, mthi/mtlo and completion write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= w_cnt_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
        end
    end

    // Next state: launch loads the buffered result; divide-by-zero buffers current HI/LO so completion is a no-op.
    always_comb begin
        w_cnt_nxt    = w_launch ? (w_is_mul ? 4'd5 : 4'd10) : (w_idle ? 4'd0 : r_cnt - 4'd1);
        w_res_hi_nxt = !w_launch ? r_res_hi : w_is_mul ? w_prod[63:32] : (rt_val == 32'd0) ? r_hi : w_rem;
        w_res_lo_nxt = !w_launch ? r_res_lo : w_is_mul ? w_prod[31:0]  : (rt_val == 32'd0) ? r_lo : w_quo;
        w_hi_nxt     = (r_cnt == 4'd1) ? r_res_hi : (w_idle & ~req & (md_op == 4'd7)) ? rs_val : r_hi;
        w_lo_nxt     = (r_cnt == 4'd1) ? r_res_lo : (w_idle & ~req & (md_op == 4'd8)) ? rs_val : r_lo;
    end

    // Outputs: busy from the run counter (optionally the launch itself), md_out from committed HI/LO.
    always_comb begin
`ifdef MDU_EARLY_BUSY_EN
        busy   = ~w_idle | w_launch;
`else
        busy   = ~w_idle;
`endif
        md_out = (md_op == 4'd5) ? r_hi : (md_op == 4'd6) ? r_lo : 32'd0;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + random checks of mult_div_unit against a cycle-count reference model.
module tb_mult_div_unit;
    logic        clk, reset, start, req, busy;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val, md_out;
    int          errs = 0, checks = 0;

    mult_div_unit dut (.clk(clk), .reset(reset), .md_op(md_op), .start(start), .rs_val(rs_val),
                       .rt_val(rt_val), .req(req), .busy(busy), .md_out(md_out));

    initial clk = 0;
    always #5 clk = ~clk;

`ifdef MDU_EARLY_BUSY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: committed HI/LO, the cycle the current operation finishes, and its result.
    longint      cyc = 0, m_done = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_pend = 0, m_ok = 0;

    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit ok, output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        ok = 1; hi = 0; lo = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1) begin
            p = sa * sb; hi = p[63:32]; lo = p[31:0];
        end else if (op == 2) begin
            p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0];
        end else if (b == 0) begin
            ok = 0;
        end else if (op == 3) begin
            q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    always @(posedge clk) begin
        bit ok;
        logic [31:0] h, l;
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_done <= 0; m_pend <= 0; m_ok <= 1;
        end else if (cyc < m_done) begin
            if (cyc + 1 == m_done && m_pend) begin
                m_hi <= m_phi; m_lo <= m_plo;
            end
        end else if (start && !req && md_op >= 1 && md_op <= 4) begin
            model_op(md_op, rs_val, rt_val, ok, h, l);
            m_pend <= ok; m_phi <= h; m_plo <= l;
            m_done <= cyc + 1 + ((md_op <= 2) ? 5 : 10);
        end else if (!req && md_op == 7) m_hi <= rs_val;
        else if (!req && md_op == 8) m_lo <= rs_val;
        cyc <= cyc + 1;
    end

    // Compare process: every cycle after the first reset edge, mid-cycle.
    always @(negedge clk) begin
        logic exp_busy;
        logic [31:0] exp_out;
        if (m_ok) begin
            exp_busy = (cyc < m_done) ||
                       (EARLY && cyc >= m_done && start && !req && md_op >= 1 && md_op <= 4);
            exp_out  = (md_op == 5) ? m_hi : (md_op == 6) ? m_lo : 32'd0;
            chk("busy_model", {31'd0, busy}, {31'd0, exp_busy});
            chk("md_out_model", md_out, exp_out);
        end
    end

    task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic rq);
        md_op = op; start = st; rs_val = a; rt_val = b; req = rq;
    endtask

    task automatic step(input logic [3:0] op, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
        drive(op, st, a, b, rq);
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, 1, a, b, 0);
        #1 chk("busy_launch_cycle", {31'd0, busy}, {31'd0, EARLY});
        @(posedge clk); #1;
    endtask

    task automatic run_idle(output int n);
        n = 0;
        drive(0, 0, 0, 0, 0);
        #1;
        while (busy && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    task automatic peek(input string nm, input logic [3:0] op, input logic [31:0] exp);
        drive(op, 0, 0, 0, 0);
        #2 chk(nm, md_out, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0);
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        peek("reset_hi", 5, 32'h0);
        peek("reset_lo", 6, 32'h0);

        launch(1, 32'hFFFFFFFF, 32'd2);
        chk("mult_busy_first", {31'd0, busy}, 32'd1);
        run_idle(n);
        chk("mult_busy_len", n, 5);
        peek("mult_hi", 5, 32'hFFFFFFFF);
        peek("mult_lo", 6, 32'hFFFFFFFE);

        launch(2, 32'hFFFFFFFF, 32'd2);
        run_idle(n);
        chk("multu_busy_len", n, 5);
        peek("multu_hi", 5, 32'h00000001);
        peek("multu_lo", 6, 32'hFFFFFFFE);

        launch(3, 32'hFFFFFFF9, 32'd2);
        run_idle(n);
        chk("div_busy_len", n, 10);
        peek("div_lo", 6, 32'hFFFFFFFD);
        peek("div_hi", 5, 32'hFFFFFFFF);

        launch(4, 32'd7, 32'd0);
        run_idle(n);
        chk("divz_busy_len", n, 10);
        peek("divz_hi", 5, 32'hFFFFFFFF);
        peek("divz_lo", 6, 32'hFFFFFFFD);

        step(7, 0, 32'h12345678, 0, 0);
        step(8, 0, 32'h9ABCDEF0, 0, 0);
        peek("mthi", 5, 32'h12345678);
        peek("mtlo", 6, 32'h9ABCDEF0);

        launch(1, 32'd3, 32'd4);
        step(8, 0, 32'd5, 0, 0);
        step(3, 1, 32'd9, 32'd3, 0);
        step(0, 0, 0, 0, 1);
        run_idle(n);
        chk("mid_run_remaining", n, 2);
        peek("mid_run_hi", 5, 32'd0);
        peek("mid_run_lo", 6, 32'd12);

        launch(3, 32'h80000000, 32'hFFFFFFFF);
        run_idle(n);
        peek("ovf_lo", 6, 32'h80000000);
        peek("ovf_hi", 5, 32'h0);

        step(1, 1, 32'd6, 32'd7, 1);
        chk("req_launch_busy", {31'd0, busy}, 32'd0);
        step(7, 0, 32'hDEADBEEF, 0, 1);
        peek("req_hi", 5, 32'h0);
        peek("req_lo", 6, 32'h80000000);

        launch(3, 32'd100, 32'd7);
        step(0, 0, 0, 0, 0);
        reset = 1;
        step(0, 0, 0, 0, 0);
        reset = 0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        peek("rst_mid_hi", 5, 32'h0);
        peek("rst_mid_lo", 6, 32'h0);
        repeat (12) step(0, 0, 0, 0, 0);
        peek("rst_no_late_write", 6, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 9);
                default: ;
            endcase
            reset = ($urandom_range(0, 99) == 0);
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a, b,
                 ($urandom_range(0, 7) == 0));
        end
        reset = 0;
        run_idle(n);
        step(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: md_op  in  4  operation: 0 free, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as free.
REQ-004 SHALL have port: start  in  1  launch of the mult/multu/div/divu operation selected by md_op.
REQ-005 SHALL have port: rs_val  in  32  operand A (dividend / multiplicand / mthi-mtlo source).
REQ-006 SHALL have port: rt_val  in  32  operand B (divisor / multiplier).
REQ-007 SHALL have port: req  in  1  exception/interrupt flush of the instruction presenting md_op this cycle.
REQ-008 SHALL have port: busy  out  1  an operation is in flight; the controller stalls MD-class instructions while set.
REQ-009 SHALL have port: md_out  out  32  HI for mfhi, LO for mflo, else 0.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 SHALL hold internal registers HI, LO (32 b each), a 4-bit down-counter cnt, and result buffers res_hi/res_lo.
REQ-012 SHALL operate as two states: IDLE (cnt==0, busy=0) and RUN (cnt!=0, busy=1).
REQ-013 In IDLE, start=1, req=0, md_op in 1..4 at edge E0: SHALL compute the result into res_hi/res_lo, load cnt=5 (mult/multu) or 10 (div/divu), enter RUN.
REQ-014 In RUN, cnt SHALL decrement each edge; on the edge where cnt goes 1->0, HI<=res_hi, LO<=res_lo and busy falls; busy is therefore high for exactly 5 (mult) or 10 (div) cycles after E0.
REQ-015 mult/multu SHALL form the 64-bit signed/unsigned product; HI=upper 32, LO=lower 32.
REQ-016 div/divu SHALL put the quotient in LO and the remainder in HI; signed division truncates toward zero, with the remainder taking the dividend's sign.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-018 Division by zero SHALL leave HI and LO unchanged while still running the full 10-cycle busy period.
REQ-019 start while in RUN SHALL be ignored; the in-flight operation continues unaffected.
REQ-020 mthi/mtlo in IDLE with req=0 SHALL write rs_val to HI/LO at the next edge; in RUN they SHALL be ignored.
REQ-021 req=1 SHALL suppress start and mthi/mtlo in the same cycle; an operation already in RUN SHALL NOT be cancelled.
REQ-022 md_out SHALL be combinational from md_op and the current HI/LO, and SHALL show pre-operation values while in RUN.
REQ-023 start=1 with md_op outside 1..4 SHALL be ignored.

Reset
REQ-024 reset=1 at an edge SHALL force HI=0, LO=0, cnt=0, busy=0, res_hi=res_lo=0, and SHALL abort any in-flight operation without updating HI/LO.
REQ-025 reset SHALL take priority over start, mthi/mtlo, and the completion write in the same cycle.

Configuration
REQ-026 Macro MDU_EARLY_BUSY_EN defined: busy SHALL equal busy_reg | (start & ~req & md_op in 1..4), so busy is high in the launch cycle itself.
REQ-027 Macro MDU_EARLY_BUSY_EN undefined: busy SHALL be the registered RUN flag only, first high the cycle after E0; all other behaviour is identical.

Verification
REQ-028 Reset, then mult with rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 div with rs=-7 (0xFFFFFFF9), rt=2 -> busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with rs=7, rt=0 -> HI/LO keep prior values, busy still 10 cycles.
REQ-030 mthi 0x12345678 then mtlo 0x9ABCDEF0 -> mfhi/mflo return those values; mtlo issued during RUN -> LO unchanged.
REQ-031 start for mult with req=1 -> busy stays 0, HI/LO unchanged; req asserted mid-RUN -> operation completes normally.
REQ-032 reset asserted at the 3rd cycle of a div -> next cycle busy=0, HI=LO=0, md_out=0 for mfhi.
REQ-033 Run both macro builds: with MDU_EARLY_BUSY_EN, busy=1 in the start cycle; without it, busy=0 in the start cycle and 1 the next.
